aes_stage_sequencer: RTL and testbench
======================================

Name: aes_stage_sequencer

Overview:
- Round controller for the file-based AES image pipeline.
- Sequences the four stage blocks (SubBytes, ShiftRows, MixColumns, AddRoundKey) through NR rounds using each stage's valid/done handshake.
- Clears each stage's sticky done by pulsing that stage's reset before every launch.
- Tells the key schedule which round key to supply, and reports completion, timeout and progress to the testbench/top level.

Parameters:
- NR, 10, number of AES rounds; legal values 10, 12, 14; any other value is a configuration error.
- TIMEOUT, 1048576, maximum cycles to wait in WAIT for a stage done before declaring an error.
- TW, 21, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request to begin a full encryption pass.
- stage_done  input  4  done flags from the stages: bit0 SB, bit1 SR, bit2 MC, bit3 ARK (sticky-high in each stage until that stage is reset).
- stage_rst  output  4  one-cycle reset pulse to the selected stage (same bit map).
- stage_valid  output  4  one-cycle launch pulse to the selected stage (same bit map).
- key_req  output  1  one-cycle pulse coincident with the ARK launch.
- round  output  4  current round index, 0..NR.
- stage_sel  output  2  current stage: 0 SB, 1 SR, 2 MC, 3 ARK.
- busy  output  1  high from CLR of the first stage until FINISH or ERROR.
- done  output  1  one-cycle pulse when the pass completes.
- error  output  1  sticky timeout flag; cleared by rst or by an accepted start.

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- States:
  - IDLE: if start=1, set round=0, stage_sel=3, clear error, go to CLR. Otherwise stay.
  - CLR: stage_rst[stage_sel]=1 for one cycle; go to LAUNCH.
  - LAUNCH: stage_valid[stage_sel]=1 for one cycle; key_req=1 if stage_sel=3; load the timeout counter with 0; go to WAIT.
  - WAIT: if stage_done[stage_sel]=1, advance the sequence (below) and go to CLR, or to FINISH after the last stage. Otherwise increment the counter; when it reaches TIMEOUT-1, go to ERROR.
  - FINISH: done=1 for one cycle, busy=0; go to IDLE.
  - ERROR: error=1, busy=0; pulse stage_rst=4'b1111 for one cycle on entry; go to IDLE. error stays high until the next accepted start.
- Sequence advance rules:
  - Round 0 is ARK only.
  - Rounds 1..NR-1 run SB, SR, MC, ARK.
  - Round NR runs SB, SR, ARK; MC is skipped.
  - ARK done in round r<NR: round increments to r+1 and stage_sel becomes 0.
  - ARK done in round NR: go to FINISH.
- Total launches are 4*NR (40 for NR=10).
- Stage_done bits other than stage_sel are ignored. stage_done is ignored in IDLE, CLR and LAUNCH.
- Timing: start sampled in IDLE at cycle t gives CLR at t+1, LAUNCH at t+2, WAIT from t+3. Done seen at cycle w gives the next CLR at w+1.
- Minimum stage period is 3 cycles (done high on the first WAIT cycle).
- start while busy is ignored, with no restart. start held high after FINISH begins a new pass from IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Stages are not pulsed; they share rst at top level.
- round and stage_sel hold their final values (NR, 3) in IDLE until the next start.

Test Plan:
- NR=10, stub stages assert done 5 cycles after valid; pulse start -> 40 valid pulses in order ARK, then (SB, SR, MC, ARK)x9, then SB, SR, ARK. No MC in round 10. key_req count 11. Exactly one done pulse, busy low afterward.
- Same stubs; measure start at cycle t -> first stage_rst[3] at t+1, first stage_valid[3] at t+2. Every stage_rst pulse immediately precedes its stage_valid pulse.
- Stub MC never asserts done in round 3, TIMEOUT=64 -> error=1 after 64 WAIT cycles, stage_rst=4'b1111 for one cycle, busy=0, round=3, stage_sel=2. A new start clears error.
- Assert start again at the 10th launch -> ignored; launch count is still 40 and there is a single done.
- Assert rst during round 5 WAIT -> all outputs 0 next edge, IDLE. A new start restarts at round 0 ARK.
- NR=14, zero-latency stubs (done on first WAIT cycle) -> 56 launches, final round 14 without MC, done at cycle t+1+56*3.

Source files
------------

// File: rtl/aes_stage_sequencer_if.sv
// aes_stage_sequencer_if: handshake bundle between the round sequencer and its stage blocks
interface aes_stage_sequencer_if;
    logic       start;
    logic [3:0] stage_done;
    logic [3:0] stage_rst;
    logic [3:0] stage_valid;
    logic       key_req;
    logic [3:0] round;
    logic [1:0] stage_sel;
    logic       busy;
    logic       done;
    logic       error;
    modport master (
        output start, stage_done,
        input  stage_rst, stage_valid, key_req, round, stage_sel, busy, done, error
    );
    modport slave (
        input  start, stage_done,
        output stage_rst, stage_valid, key_req, round, stage_sel, busy, done, error
    );
endinterface

// File: rtl/aes_stage_sequencer.sv
// aes_stage_sequencer: walks SB/SR/MC/ARK through NR rounds with clear-launch-wait per stage
module aes_stage_sequencer #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 1048576,
    parameter int TW      = 21
) (
    input logic clk,
    input logic rst,
    aes_stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT, FINISH, ERROR} state_t;
    localparam logic [3:0]    NRW  = 4'(NR);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_stage_sequencer: NR must be 10, 12 or 14");
    end
    if (longint'(TIMEOUT) >= (longint'(1) << TW)) begin : g_bad_tw
        $error("aes_stage_sequencer: TW too narrow for TIMEOUT");
    end
    state_t        state;
    logic [TW-1:0] cnt;
    logic [1:0]    nxt_sel;
    logic          last;
    // final round skips MC: SR hands straight to ARK
    always_comb begin
        last    = bus.stage_sel == 2'd3 && bus.round == NRW;
        nxt_sel = bus.stage_sel == 2'd3 ? 2'd0 :
                  (bus.stage_sel == 2'd1 && bus.round == NRW) ? 2'd3 : bus.stage_sel + 2'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.stage_rst   <= '0;
            bus.stage_valid <= '0;
            bus.key_req     <= 1'b0;
            bus.round       <= '0;
            bus.stage_sel   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
        end else begin
            bus.stage_rst   <= '0;
            bus.stage_valid <= '0;
            bus.key_req     <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bus.round     <= '0;
                    bus.stage_sel <= 2'd3;
                    bus.error     <= 1'b0;
                    bus.busy      <= 1'b1;
                    bus.stage_rst <= 4'b1000;
                    state         <= CLR;
                end
                CLR: begin
                    bus.stage_valid <= 4'b0001 << bus.stage_sel;
                    bus.key_req     <= bus.stage_sel == 2'd3;
                    state           <= LAUNCH;
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (bus.stage_done[bus.stage_sel]) begin
                    if (last) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= FINISH;
                    end else begin
                        bus.round     <= bus.stage_sel == 2'd3 ? bus.round + 4'd1 : bus.round;
                        bus.stage_sel <= nxt_sel;
                        bus.stage_rst <= 4'b0001 << nxt_sel;
                        state         <= CLR;
                    end
                end else if (cnt == TMAX) begin
                    bus.error     <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.stage_rst <= 4'b1111;
                    state         <= ERROR;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_stage_sequencer.sv
// tb_aes_stage_sequencer: scoreboard of expected launch order against stub stages
module tb_aes_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic hang = 1'b0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [3:0] sd_a = '0;
    logic [3:0] sd_b = '0;
    int   lat_a[4];
    int   n_launch_a = 0, n_key_a = 0, n_done_a = 0, last_launch_cyc = 0;
    int   n_launch_b = 0, n_done_b = 0, done_cyc_b = 0;
    logic [3:0] prev_rst_a = '0, prev_rst_b = '0;
    logic [17:0] outs_a;

    aes_stage_sequencer_if ia();
    aes_stage_sequencer_if ib();

    aes_stage_sequencer #(.NR(10), .TIMEOUT(64), .TW(7)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    aes_stage_sequencer #(.NR(14)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ia.stage_done = sd_a;
    assign ib.stage_done = sd_b;
    assign outs_a = {ia.stage_rst, ia.stage_valid, ia.key_req, ia.round, ia.stage_sel,
                     ia.busy, ia.done, ia.error};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_launch(int nr, int k);
        int r, s;
        if (k == 0) return 8'h08;
        r = (k - 1) / 4 + 1;
        s = (k - 1) % 4;
        if (r == nr && s == 2) s = 3;
        return {4'(r), 4'(1 << s)};
    endfunction

    // stage stubs: A answers 5 cycles after valid (MC can hang in round 3), B answers at once
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || ia.stage_rst[i]) begin
                sd_a[i]  <= 1'b0;
                lat_a[i] <= 0;
            end else if (ia.stage_valid[i]) begin
                lat_a[i] <= 5;
            end else if (lat_a[i] != 0) begin
                lat_a[i] <= lat_a[i] - 1;
                if (lat_a[i] == 1 && !(hang && i == 2 && ia.round == 4'd3)) sd_a[i] <= 1'b1;
            end
            if (rst || ib.stage_rst[i]) sd_b[i] <= 1'b0;
            else if (ib.stage_valid[i]) sd_b[i] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && ia.stage_valid != 4'b0) begin
            n_launch_a++;
            last_launch_cyc = cyc;
            if (exp_a.size() == 0) check("a_extra_launch", 32'({ia.round, ia.stage_valid}), 32'hff);
            else check("a_launch", 32'({ia.round, ia.stage_valid}), 32'(exp_a.pop_front()));
            check("a_rst_before_valid", 32'(prev_rst_a), 32'(ia.stage_valid));
            check("a_key_req", 32'(ia.key_req), 32'(ia.stage_valid[3]));
        end
        if (ia.key_req) n_key_a++;
        if (ia.done) n_done_a++;
        prev_rst_a = ia.stage_rst;
        if (!rst && ib.stage_valid != 4'b0) begin
            n_launch_b++;
            if (exp_b.size() == 0) check("b_extra_launch", 32'({ib.round, ib.stage_valid}), 32'hff);
            else check("b_launch", 32'({ib.round, ib.stage_valid}), 32'(exp_b.pop_front()));
            check("b_rst_before_valid", 32'(prev_rst_b), 32'(ib.stage_valid));
        end
        if (ib.done) begin
            n_done_b++;
            done_cyc_b = cyc;
        end
        prev_rst_b = ib.stage_rst;
    end

    task automatic start_a();
        @(negedge clk);
        ia.start = 1'b1;
        @(posedge clk);
        #1;
        ia.start = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 5000 && n_done_a == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c0;
        ia.start = 1'b0;
        ib.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // full NR=10 pass, with a stray start at the 10th launch
        for (int k = 0; k < 40; k++) exp_a.push_back(exp_launch(10, k));
        n_launch_a = 0; n_key_a = 0; n_done_a = 0;
        start_a();
        check("first_clr_rst", 32'(ia.stage_rst), 32'h8);
        check("busy_in_clr", 32'(ia.busy), 1);
        @(posedge clk);
        #1;
        check("first_valid", 32'(ia.stage_valid), 32'h8);
        for (int i = 0; i < 2000 && n_launch_a < 10; i++) @(negedge clk);
        ia.start = 1'b1;
        repeat (3) @(negedge clk);
        ia.start = 1'b0;
        wait_done_a();
        check("pass_launches", 32'(n_launch_a), 40);
        check("pass_key_reqs", 32'(n_key_a), 11);
        check("pass_done_pulses", 32'(n_done_a), 1);
        check("pass_busy_after", 32'(ia.busy), 0);
        check("pass_final_round", 32'(ia.round), 10);
        check("pass_final_sel", 32'(ia.stage_sel), 3);
        check("pass_queue_empty", 32'(exp_a.size()), 0);

        // MC hangs in round 3 -> timeout
        hang = 1'b1;
        for (int k = 0; k < 12; k++) exp_a.push_back(exp_launch(10, k));
        start_a();
        for (int i = 0; i < 3000 && !ia.error; i++) @(negedge clk);
        check("to_error", 32'(ia.error), 1);
        check("to_wait_cycles", 32'(cyc - last_launch_cyc), 65);
        check("to_stage_rst_all", 32'(ia.stage_rst), 32'hf);
        check("to_busy", 32'(ia.busy), 0);
        check("to_round", 32'(ia.round), 3);
        check("to_sel", 32'(ia.stage_sel), 2);
        @(negedge clk);
        check("to_rst_one_cycle", 32'(ia.stage_rst), 0);
        check("to_error_sticky", 32'(ia.error), 1);
        check("to_queue_empty", 32'(exp_a.size()), 0);
        hang = 1'b0;

        // restart clears error; reset in the middle of round 5
        for (int k = 0; k < 40; k++) exp_a.push_back(exp_launch(10, k));
        start_a();
        check("restart_clears_error", 32'(ia.error), 0);
        for (int i = 0; i < 3000 && ia.round != 4'd5; i++) @(negedge clk);
        check("reached_round5", 32'(ia.round), 5);
        repeat (3) @(negedge clk);
        exp_a.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", 32'(outs_a), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) exp_a.push_back(exp_launch(10, k));
        n_launch_a = 0; n_key_a = 0; n_done_a = 0;
        start_a();
        wait_done_a();
        check("after_reset_launches", 32'(n_launch_a), 40);
        check("after_reset_done", 32'(n_done_a), 1);
        check("after_reset_queue", 32'(exp_a.size()), 0);

        // NR=14 with zero-latency stages
        for (int k = 0; k < 56; k++) exp_b.push_back(exp_launch(14, k));
        @(negedge clk);
        ib.start = 1'b1;
        @(posedge clk);
        #1;
        ib.start = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 1000 && n_done_b == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("b_done_pulses", 32'(n_done_b), 1);
        check("b_done_cycle", 32'(done_cyc_b - c0), 168);
        check("b_launches", 32'(n_launch_b), 56);
        check("b_final_round", 32'(ib.round), 14);
        check("b_queue_empty", 32'(exp_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
